ps2_key_tracker: RTL and testbench

Synchronous scancode interpreter that sits directly downstream of the PS/2 frame receiver. It consumes validated Set-2 scancode bytes, resolves E0 (extended), F0 (break) and E1 (pause) prefix sequences, and keeps a held-key bitmap for both players. It drives level-stable `p1keys`/`p2keys` to the game logic: a bit stays high from the key's make code until its break code.

---
 rtl/ps2_key_tracker.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scancode interpreter: resolves E0/F0/E1 prefixes and keeps a
// level-stable held-key bitmap for two players plus two system keys.
module ps2_key_tracker #(
   parameter int unsigned TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [4:0] p1keys,
   output logic [4:0] p2keys,
   output logic [1:0] sys_keys,
   output logic       key_event,
   output logic       key_release
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EXT     = 3'd1;
   localparam logic [2:0] ST_BRK     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK = 3'd3;
   localparam logic [2:0] ST_SKIP    = 3'd4;

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   // Bitmap layout: [4:0] player 1, [9:5] player 2, [11:10] system keys.
   function automatic logic [11:0] key_mask(input logic [7:0] code);
      logic [11:0] m;
      m = 12'd0;
      case (code)
         8'h75:   m[0]  = 1'b1;
         8'h6B:   m[1]  = 1'b1;
         8'h74:   m[2]  = 1'b1;
         8'h72:   m[3]  = 1'b1;
         8'h29:   m[4]  = 1'b1;
         8'h1D:   m[5]  = 1'b1;
         8'h1C:   m[6]  = 1'b1;
         8'h23:   m[7]  = 1'b1;
         8'h1B:   m[8]  = 1'b1;
         8'h0D:   m[9]  = 1'b1;
         8'h5A:   m[10] = 1'b1;
         8'h66:   m[11] = 1'b1;
         default: m     = 12'd0;
      endcase
      return m;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [2:0]  skip_q, skip_d;
   logic [15:0] tmo_q, tmo_d;
   logic [11:0] keys_q, keys_d;
   logic        event_q, event_d;
   logic        release_q, release_d;

   logic        do_make;
   logic        do_break;
   logic        do_clear;
   logic [11:0] mask;

   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      tmo_d    = tmo_q;
      do_make  = 1'b0;
      do_break = 1'b0;
      do_clear = 1'b0;
      mask     = key_mask(rx_data);

      if (rx_err) begin
         state_d = ST_IDLE;
         tmo_d   = 16'd0;
         skip_d  = 3'd0;
      end else if (rx_valid) begin
         tmo_d = 16'd0;
         case (state_q)
            ST_IDLE: begin
               case (rx_data)
                  8'hE0: state_d = ST_EXT;
                  8'hF0: state_d = ST_BRK;
                  8'hE1: begin
                     state_d = ST_SKIP;
                     skip_d  = 3'd7;
                  end
                  8'hAA, 8'h00, 8'hFF: do_clear = 1'b1;
                  8'hFA, 8'hFE: ;
                  default: do_make = 1'b1;
               endcase
            end
            ST_EXT: begin
               // E0 12 / E0 7C are the fake-shift bytes wrapped around arrows.
               case (rx_data)
                  8'hF0:        state_d = ST_EXT_BRK;
                  8'h12, 8'h7C: state_d = ST_IDLE;
                  default: begin
                     do_make = 1'b1;
                     state_d = ST_IDLE;
                  end
               endcase
            end
            ST_BRK, ST_EXT_BRK: begin
               do_break = 1'b1;
               state_d  = ST_IDLE;
            end
            ST_SKIP: begin
               if (skip_q <= 3'd1) begin
                  skip_d  = 3'd0;
                  state_d = ST_IDLE;
               end else begin
                  skip_d = skip_q - 3'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q >= TMO_LIMIT) begin
            state_d = ST_IDLE;
            tmo_d   = 16'd0;
            skip_d  = 3'd0;
         end else if (tmo_q != 16'hFFFF) begin
            tmo_d = tmo_q + 16'd1;
         end
      end
   end

   always_comb begin
      keys_d = keys_q;
      if (do_clear) begin
         keys_d = 12'd0;
      end else if (do_make) begin
         keys_d = keys_q | mask;
      end else if (do_break) begin
         keys_d = keys_q & ~mask;
      end
      event_d   = (keys_d != keys_q);
      release_d = event_d & (do_break | do_clear);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         skip_q    <= 3'd0;
         tmo_q     <= 16'd0;
         keys_q    <= 12'd0;
         event_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         skip_q    <= skip_d;
         tmo_q     <= tmo_d;
         keys_q    <= keys_d;
         event_q   <= event_d;
         release_q <= release_d;
      end
   end

   assign p1keys      = keys_q[4:0];
   assign p2keys      = keys_q[9:5];
   assign sys_keys    = keys_q[11:10];
   assign key_event   = event_q;
   assign key_release = release_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker; each task drives one
// scenario and compares {p1keys, p2keys, sys_keys, key_event, key_release}.
module tb_ps2_key_tracker;

   localparam int unsigned TMO = 20;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic [4:0] p1keys;
   logic [4:0] p2keys;
   logic [1:0] sys_keys;
   logic       key_event;
   logic       key_release;
   logic [13:0] obs;

   int checks;
   int errors;

   ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_err      (rx_err),
      .p1keys      (p1keys),
      .p2keys      (p2keys),
      .sys_keys    (sys_keys),
      .key_event   (key_event),
      .key_release (key_release)
   );

   assign obs = {p1keys, p2keys, sys_keys, key_event, key_release};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Called at a negedge; returns at the next negedge, where the byte's effect is visible.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
      #12;
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL reset_state: got %b want %b", obs, 14'd0); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL after_reset_release: got %b want %b", obs, 14'd0); end
   endtask

   task automatic test_make_break;
      send_byte(8'h1D);
      checks++;
      if (obs !== 14'b00000_00001_00_1_0) begin errors++; $display("FAIL w_make: got %b want %b", obs, 14'b00000_00001_00_1_0); end
      send_byte(8'hF0);
      checks++;
      if (obs !== 14'b00000_00001_00_0_0) begin errors++; $display("FAIL brk_prefix: got %b want %b", obs, 14'b00000_00001_00_0_0); end
      send_byte(8'h1D);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL w_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_extended;
      send_byte(8'hE0);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL ext_prefix: got %b want %b", obs, 14'd0); end
      send_byte(8'h75);
      checks++;
      if (obs !== 14'b00001_00000_00_1_0) begin errors++; $display("FAIL ext_up_make: got %b want %b", obs, 14'b00001_00000_00_1_0); end
      send_byte(8'h1C);
      checks++;
      if (obs !== 14'b00001_00010_00_1_0) begin errors++; $display("FAIL a_make: got %b want %b", obs, 14'b00001_00010_00_1_0); end
      send_byte(8'hE0);
      send_byte(8'hF0);
      checks++;
      if (obs !== 14'b00001_00010_00_0_0) begin errors++; $display("FAIL ext_brk_prefix: got %b want %b", obs, 14'b00001_00010_00_0_0); end
      send_byte(8'h75);
      checks++;
      if (obs !== 14'b00000_00010_00_1_1) begin errors++; $display("FAIL ext_up_break: got %b want %b", obs, 14'b00000_00010_00_1_1); end
      send_byte(8'hF0);
      send_byte(8'h1C);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL a_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_fake_shift;
      send_byte(8'hE0);
      send_byte(8'h12);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL fake_shift_12: got %b want %b", obs, 14'd0); end
      send_byte(8'hE0);
      send_byte(8'h7C);
      send_byte(8'h11);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL fake_7c_unmapped: got %b want %b", obs, 14'd0); end
      send_byte(8'h6B);
      checks++;
      if (obs !== 14'b00010_00000_00_1_0) begin errors++; $display("FAIL left_after_fake: got %b want %b", obs, 14'b00010_00000_00_1_0); end
      send_byte(8'hF0);
      send_byte(8'h6B);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL left_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_pause;
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) begin
         send_byte(seq[i]);
         checks++;
         if (obs !== 14'd0) begin errors++; $display("FAIL pause_byte%0d: got %b want %b", i, obs, 14'd0); end
      end
      send_byte(8'h29);
      checks++;
      if (obs !== 14'b10000_00000_00_1_0) begin errors++; $display("FAIL fire_after_pause: got %b want %b", obs, 14'b10000_00000_00_1_0); end
      // Seven skipped bytes after E1, including a break and a clear code.
      send_byte(8'hE1);
      send_byte(8'hF0);
      send_byte(8'h29);
      for (int i = 0; i < 5; i++) send_byte(8'h00);
      checks++;
      if (obs !== 14'b10000_00000_00_0_0) begin errors++; $display("FAIL skip_holds_keys: got %b want %b", obs, 14'b10000_00000_00_0_0); end
      send_byte(8'hF0);
      send_byte(8'h29);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL fire_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_duplicate;
      send_byte(8'h75);
      send_byte(8'h75);
      checks++;
      if (obs !== 14'b00001_00000_00_0_0) begin errors++; $display("FAIL dup_make: got %b want %b", obs, 14'b00001_00000_00_0_0); end
      send_byte(8'hF0);
      send_byte(8'h1D);
      checks++;
      if (obs !== 14'b00001_00000_00_0_0) begin errors++; $display("FAIL break_clear_bit: got %b want %b", obs, 14'b00001_00000_00_0_0); end
      send_byte(8'hF0);
      send_byte(8'h75);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL dup_cleanup: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_clear;
      send_byte(8'h29);
      send_byte(8'h5A);
      checks++;
      if (obs !== 14'b10000_00000_01_1_0) begin errors++; $display("FAIL enter_make: got %b want %b", obs, 14'b10000_00000_01_1_0); end
      send_byte(8'hAA);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL aa_clear: got %b want %b", obs, 14'b00000_00000_00_1_1); end
      send_byte(8'hFF);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL ff_clear_empty: got %b want %b", obs, 14'd0); end
      send_byte(8'h66);
      send_byte(8'hFA);
      send_byte(8'hFE);
      checks++;
      if (obs !== 14'b00000_00000_10_0_0) begin errors++; $display("FAIL fa_fe_ignored: got %b want %b", obs, 14'b00000_00000_10_0_0); end
      send_byte(8'h00);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL zero_clear: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_timeout;
      send_byte(8'hF0);
      repeat (TMO + 1) @(negedge clk);
      send_byte(8'h23);
      checks++;
      if (obs !== 14'b00000_00100_00_1_0) begin errors++; $display("FAIL timeout_make: got %b want %b", obs, 14'b00000_00100_00_1_0); end
      // Byte lands in the very cycle the counter reaches the limit: still a break.
      send_byte(8'hF0);
      repeat (TMO) @(negedge clk);
      send_byte(8'h23);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL edge_timeout_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_rx_err;
      send_byte(8'hE0);
      rx_err = 1'b1;
      send_byte(8'hF0);
      rx_err = 1'b0;
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL err_drop: got %b want %b", obs, 14'd0); end
      send_byte(8'h72);
      checks++;
      if (obs !== 14'b01000_00000_00_1_0) begin errors++; $display("FAIL down_after_err: got %b want %b", obs, 14'b01000_00000_00_1_0); end
      send_byte(8'hF0);
      rx_err = 1'b1;
      @(negedge clk);
      rx_err = 1'b0;
      checks++;
      if (obs !== 14'b01000_00000_00_0_0) begin errors++; $display("FAIL err_keeps_keys: got %b want %b", obs, 14'b01000_00000_00_0_0); end
      send_byte(8'h72);
      checks++;
      if (obs !== 14'b01000_00000_00_0_0) begin errors++; $display("FAIL err_then_make: got %b want %b", obs, 14'b01000_00000_00_0_0); end
      send_byte(8'hF0);
      send_byte(8'h72);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL down_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_back_to_back;
      send_byte(8'h74);
      checks++;
      if (obs !== 14'b00100_00000_00_1_0) begin errors++; $display("FAIL b2b_make1: got %b want %b", obs, 14'b00100_00000_00_1_0); end
      send_byte(8'hF0);
      checks++;
      if (obs !== 14'b00100_00000_00_0_0) begin errors++; $display("FAIL b2b_prefix: got %b want %b", obs, 14'b00100_00000_00_0_0); end
      send_byte(8'h74);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL b2b_break: got %b want %b", obs, 14'b00000_00000_00_1_1); end
      send_byte(8'h74);
      checks++;
      if (obs !== 14'b00100_00000_00_1_0) begin errors++; $display("FAIL b2b_remake: got %b want %b", obs, 14'b00100_00000_00_1_0); end
      send_byte(8'h0D);
      checks++;
      if (obs !== 14'b00100_10000_00_1_0) begin errors++; $display("FAIL b2b_tab: got %b want %b", obs, 14'b00100_10000_00_1_0); end
      send_byte(8'hAA);
      checks++;
      if (obs !== 14'b00000_00000_00_1_1) begin errors++; $display("FAIL b2b_clear: got %b want %b", obs, 14'b00000_00000_00_1_1); end
   endtask

   task automatic test_reset_midseq;
      send_byte(8'h6B);
      send_byte(8'hE0);
      send_byte(8'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL async_reset: got %b want %b", obs, 14'd0); end
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h6B);
      checks++;
      if (obs !== 14'b00010_00000_00_1_0) begin errors++; $display("FAIL orphan_make: got %b want %b", obs, 14'b00010_00000_00_1_0); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_make_break();
      test_extended();
      test_fake_shift();
      test_pause();
      test_duplicate();
      test_clear();
      test_timeout();
      test_rx_err();
      test_back_to_back();
      test_reset_midseq();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
